// File: rtl/loss.sv
// Output-layer error generator: pairs activation/target, emits (act - tgt) <<< SHIFT one cycle after the pair when training.
// Operands stall (ready low) while one is already held or while an error waits for error_ready; error is held stable until accepted.
module loss #(
  parameter int SHIFT     = 0,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 train,
  input  logic                 clear,
  input  logic                 activation_valid,
  output logic                 activation_ready,
  input  logic [7:0]           activation_data,
  input  logic                 target_valid,
  output logic                 target_ready,
  input  logic [7:0]           target_data,
  output logic                 error_valid,
  input  logic                 error_ready,
  output logic [15:0]          error_data,
  output logic [ACC_WIDTH-1:0] sse,
  output logic [CNT_WIDTH-1:0] count
);

  typedef enum logic {COLLECT, SEND} state_t;

  state_t                 state_q, state_d;
  logic                   act_held_q, act_held_d;
  logic                   tgt_held_q, tgt_held_d;
  logic [7:0]             act_q, act_d;
  logic [7:0]             tgt_q, tgt_d;
  logic [15:0]            err_q, err_d;
  logic [ACC_WIDTH-1:0]   sse_q, sse_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic                   act_fire, tgt_fire, pair;
  logic [7:0]             act_val, tgt_val;
  logic [8:0]             diff;
  logic [7:0]             diff_abs;
  logic [15:0]            diff_sq;
  logic [15:0]            diff_ext;
  logic [ACC_WIDTH-1:0]   sse_base;
  logic [CNT_WIDTH-1:0]   cnt_base;
  logic [ACC_WIDTH:0]     sse_sum;

  assign activation_ready = (state_q == COLLECT) && !act_held_q;
  assign target_ready     = (state_q == COLLECT) && !tgt_held_q;
  assign act_fire         = activation_valid && activation_ready;
  assign tgt_fire         = target_valid && target_ready;

  // A held operand stands in for the missing handshake of the current cycle.
  assign act_val = act_held_q ? act_q : activation_data;
  assign tgt_val = tgt_held_q ? tgt_q : target_data;
  assign pair    = (state_q == COLLECT) && (act_held_q || act_fire) && (tgt_held_q || tgt_fire);

  assign diff     = {1'b0, act_val} - {1'b0, tgt_val};
  assign diff_abs = diff[8] ? 8'(-diff) : diff[7:0];
  assign diff_sq  = {8'h00, diff_abs} * {8'h00, diff_abs};
  assign diff_ext = {{7{diff[8]}}, diff};

  // Clear applies before the pair's contribution in the same cycle.
  assign sse_base = clear ? '0 : sse_q;
  assign cnt_base = clear ? '0 : cnt_q;
  assign sse_sum  = {1'b0, sse_base} + {{(ACC_WIDTH-15){1'b0}}, diff_sq};

  always_comb begin
    state_d    = state_q;
    act_held_d = act_held_q;
    tgt_held_d = tgt_held_q;
    act_d      = act_q;
    tgt_d      = tgt_q;
    err_d      = err_q;
    sse_d      = sse_base;
    cnt_d      = cnt_base;

    case (state_q)
      COLLECT: begin
        if (pair) begin
          act_held_d = 1'b0;
          tgt_held_d = 1'b0;
          err_d      = diff_ext <<< SHIFT;
          cnt_d      = cnt_base + CNT_WIDTH'(1);
          sse_d      = sse_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sse_sum[ACC_WIDTH-1:0];
          if (train) state_d = SEND;
        end else begin
          if (act_fire) begin
            act_held_d = 1'b1;
            act_d      = activation_data;
          end
          if (tgt_fire) begin
            tgt_held_d = 1'b1;
            tgt_d      = target_data;
          end
        end
      end
      SEND: begin
        if (error_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= COLLECT;
      act_held_q <= 1'b0;
      tgt_held_q <= 1'b0;
      act_q      <= '0;
      tgt_q      <= '0;
      err_q      <= '0;
      sse_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      act_held_q <= act_held_d;
      tgt_held_q <= tgt_held_d;
      act_q      <= act_d;
      tgt_q      <= tgt_d;
      err_q      <= err_d;
      sse_q      <= sse_d;
      cnt_q      <= cnt_d;
    end
  end

  assign error_valid = (state_q == SEND);
  assign error_data  = err_q;
  assign sse         = sse_q;
  assign count       = cnt_q;

endmodule
